// File: rtl/hilo_multiplier_if.sv
// hilo_multiplier_if
//   Request/response bundle between the register-read stage and the HI/LO
//   multiplier.
//   Signal  : function code (shared with the writeback selector)
//   start   : request strobe, only meaningful when Signal is MULTU
//   dataA   : multiplicand (rs)
//   dataB   : multiplier (rt)
//   busy    : multiply in progress
//   done    : one-cycle pulse when HI/LO were just committed
//   HiOut   : HI register
//   LoOut   : LO register
interface hilo_multiplier_if #(
  parameter int WIDTH = 32
);
  logic [5:0]       Signal;
  logic             start;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] HiOut;
  logic [WIDTH-1:0] LoOut;

  modport master (
    output Signal, start, dataA, dataB,
    input  busy, done, HiOut, LoOut
  );

  modport slave (
    input  Signal, start, dataA, dataB,
    output busy, done, HiOut, LoOut
  );
endinterface

// File: rtl/hilo_multiplier.sv
// hilo_multiplier
//   Sequential unsigned shift-add multiplier (MULTU) that owns HI/LO.
//   One iteration per clock; the full 2*WIDTH product commits to HI/LO in
//   a single edge, so MFHI/MFLO never observe a half-updated pair.
//   clk   : single clock, rising edge
//   reset : synchronous, active-low; clears every register
//   bus   : slave side of hilo_multiplier_if (request in, busy/done/HI/LO out)
//   CNT_W must satisfy 2**CNT_W > WIDTH so the counter can reach WIDTH-1.
module hilo_multiplier #(
  parameter int         WIDTH = 32,
  parameter int         CNT_W = 6,
  parameter logic [5:0] MULTU = 6'b011001
) (
  input  logic               clk,
  input  logic               reset,
  hilo_multiplier_if.slave   bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [2*WIDTH-1:0] prod_reg, prod_next;
  logic [WIDTH-1:0]   mcand_reg, mcand_next;
  logic [WIDTH-1:0]   hi_reg, hi_next;
  logic [WIDTH-1:0]   lo_reg, lo_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;

  // One shift-add step. The add is WIDTH+1 bits so the carry out of the
  // upper half is shifted back in instead of being lost.
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] step;

  always_comb begin
    sum  = {1'b0, prod_reg[2*WIDTH-1:WIDTH]}
         + (prod_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
    step = {sum, prod_reg[WIDTH-1:1]};
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    prod_next  = prod_reg;
    mcand_next = mcand_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start && (bus.Signal == MULTU)) begin
          // Operands are captured only here; the bus may change afterwards.
          mcand_next = bus.dataA;
          prod_next  = {{WIDTH{1'b0}}, bus.dataB};
          cnt_next   = '0;
          busy_next  = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        prod_next = step;
        cnt_next  = cnt_reg + 1'b1;
        // Last iteration: commit the freshly computed product directly so
        // HI/LO update on the same edge that busy drops.
        if (cnt_reg == CNT_W'(WIDTH - 1)) begin
          hi_next    = step[2*WIDTH-1:WIDTH];
          lo_next    = step[WIDTH-1:0];
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      prod_reg  <= '0;
      mcand_reg <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      prod_reg  <= prod_next;
      mcand_reg <= mcand_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign bus.busy  = busy_reg;
  assign bus.done  = done_reg;
  assign bus.HiOut = hi_reg;
  assign bus.LoOut = lo_reg;

endmodule
